dm_ctrl: RTL

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_ctrl_pkg.sv | 48 ++++
 rtl/dm_ctrl_lane_mux.sv | 38 +++
 rtl/dm_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: opcodes, FSM states,
// strobe polarities and alignment helpers.
package dm_ctrl_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic DM_R_ON = 1'b1;
    localparam logic DM_W_ON = 1'b1;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Request fields held for the duration of one access.
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] wdata;
    } req_lat_t;

    function automatic logic is_load(input op_e op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_misaligned(input op_e op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_lane_mux.sv
// Little-endian lane extraction for loads and lane merge for sub-word stores.
module dm_lane_mux
    import dm_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr,
    input  op_e               op,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr, 3'b000} +: 8];
        half_v = word[{addr[1], 4'b0000} +: 16];

        load_val = word;
        case (op)
            OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_val = {24'd0, byte_v};
            OP_LH:   load_val = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_val = {16'd0, half_v};
            default: load_val = word;
        endcase

        store_word = word;
        case (op)
            OP_SB:   store_word[{addr, 3'b000} +: 8]     = wdata[7:0];
            OP_SH:   store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: sequences loads, word stores and sub-word
// read-modify-write stores for the MEM stage, stalling the pipeline meanwhile.
module dm_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              exc_misalign,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_r,
    output logic              dm_w,
    input  logic [DATA_W-1:0] dm_rdata
);

    state_e            state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    req_lat_t          lat_q, lat_next;
    op_e               op_in;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;

    assign op_in = op_e'(req_op);

    // Memory word is consumed at the edge that ends the read cycle.
    dm_lane_mux u_lane_mux (
        .word       (dm_rdata),
        .addr       (addr_q[1:0]),
        .op         (lat_q.op),
        .wdata      (lat_q.wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        lat_next   = lat_q;
        stall      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    stall          = 1'b1;
                    addr_next      = req_addr;
                    lat_next.op    = op_in;
                    lat_next.wdata = req_wdata;
                    if (is_misaligned(op_in, req_addr[1:0])) begin
                        state_next = ST_DONE;
                    end else if (is_load(op_in)) begin
                        state_next = ST_LOAD;
                    end else if (op_in == OP_SW) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                stall      = 1'b1;
                state_next = ST_DONE;
            end
            ST_WRITE: begin
                stall      = 1'b1;
                state_next = ST_DONE;
            end
            ST_RMW_RD: begin
                stall      = 1'b1;
                state_next = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                stall      = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            lat_q        <= '{op: OP_LW, wdata: '0};
            dm_r         <= ~DM_R_ON;
            dm_w         <= ~DM_W_ON;
            resp_valid   <= 1'b0;
            exc_misalign <= 1'b0;
            resp_rdata   <= '0;
            dm_wdata     <= '0;
            dm_addr      <= '0;
        end else begin
            state        <= state_next;
            addr_q       <= addr_next;
            lat_q        <= lat_next;
            dm_r         <= (state_next == ST_LOAD || state_next == ST_RMW_RD) ? DM_R_ON : ~DM_R_ON;
            dm_w         <= (state_next == ST_WRITE || state_next == ST_RMW_WR) ? DM_W_ON : ~DM_W_ON;
            resp_valid   <= state_next == ST_DONE;
            exc_misalign <= (state == ST_IDLE) && (state_next == ST_DONE);
            dm_addr      <= (state_next == ST_IDLE) ? '0 : {addr_next[ADDR_W-1:2], 2'b00};
            if (state_next == ST_WRITE) begin
                dm_wdata <= lat_next.wdata;
            end else if (state_next == ST_RMW_WR) begin
                dm_wdata <= store_word;
            end
            if (state == ST_LOAD) begin
                resp_rdata <= load_val;
            end
        end
    end

endmodule
